reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the CPU register file: configurable data width, depth and read-port count, with two write ports.
- Adds a per-register busy scoreboard (allocate at issue, clear at writeback) so the pipeline can stall on pending results.
- Adds a sequenced bulk-clear engine that zeroes the file without a reset.
- Sits between decode/issue (reads, allocate) and writeback (write ports A and B).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- RESET_MODE, 1: 0 = all registers reset to 0; 1 = register i resets to i (test preload), truncated to DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies slice k.
- rd_data  out  NUM_RD*DATA_W  read data, combinational.
- rd_ready  out  NUM_RD  port k operand valid (not busy).
- wa_en  in  1  write port A enable.
- wa_addr  in  ADDR_W  write port A address.
- wa_data  in  DATA_W  write port A data.
- wb_en  in  1  write port B enable.
- wb_addr  in  ADDR_W  write port B address.
- wb_data  in  DATA_W  write port B data.
- alloc_en  in  1  mark a destination register busy.
- alloc_addr  in  ADDR_W  destination being allocated.
- clr_req  in  1  start a bulk-clear sweep (sampled only in IDLE).
- clr_busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse when a sweep completes.
- busy_vec  out  DEPTH  scoreboard bits, for debug and bench.

Behaviour:
- Reset (reset_n low, async):
  - Registers take their RESET_MODE values; register 0 is always 0.
  - busy_vec = 0; FSM goes to IDLE; clr_busy = 0; clr_done = 0.
  - A reset during a sweep aborts it and produces no clr_done.
- Register 0 is hardwired to zero:
  - Writes to address 0 are dropped.
  - Allocates to address 0 are dropped.
  - Reads of address 0 return 0 with rd_ready = 1.
- Writes (IDLE only):
  - Each enabled port writes its register on the rising edge and clears that register's busy bit.
  - If wa_addr == wb_addr and both ports are enabled, port B data wins.
- Allocate (IDLE only):
  - alloc_en sets busy[alloc_addr] on the edge.
  - If alloc and a write hit the same address in the same cycle, busy ends at 1 (allocate wins); the data write still lands.
- Reads are combinational, per port k, in priority order:
  - Address 0 returns 0.
  - In IDLE, wb_en with matching address bypasses wb_data.
  - Otherwise in IDLE, wa_en with matching address bypasses wa_data.
  - Otherwise the array value is returned.
- rd_ready[k]:
  - 0 whenever clr_busy = 1.
  - Otherwise 1 if address is 0, or the busy bit is clear, or an enabled write port targets that address this cycle (bypass).
  - Same-cycle alloc does not affect rd_ready until the next cycle.
- Clear FSM, states IDLE, SWEEP, DONE:
  - IDLE: clr_req = 1 moves to SWEEP and loads cnt = 0. Latency: clr_busy rises the cycle after clr_req.
  - SWEEP: clr_busy = 1. Each cycle, registers[cnt] <= 0 and busy[cnt] <= 0, then cnt increments. When cnt == DEPTH-1, move to DONE. The sweep takes exactly DEPTH cycles.
  - SWEEP: wa/wb writes and allocs are dropped (not queued), read bypass is disabled, and clr_req is ignored.
  - DONE: clr_busy = 0, clr_done = 1 for one cycle, then IDLE. Writes and allocs are accepted again from the DONE cycle.
- cnt is ADDR_W bits wide and does not wrap past DEPTH-1.
- Out-of-range NUM_RD (outside 1..4) is a static configuration error, enforced by an elaboration check.

Test Plan:
- Reset with RESET_MODE=1, DATA_W=32, ADDR_W=5 -> r0..r10 read 0,1..10; r31 reads 31; busy_vec = 0; clr_busy = 0.
- Same cycle: wa_en to r5 = 0xAAAA and wb_en to r5 = 0x5555, port 0 reads r5 -> rd_data = 0x5555 in that cycle; array holds 0x5555 next cycle.
- Scoreboard:
  - alloc r7 -> next cycle rd_ready for r7 = 0.
  - wa_en r7 = 0x1234 -> rd_ready = 1 with data 0x1234 in the same cycle.
  - alloc r7 plus wa r7 in the same cycle -> busy[7] = 1 afterwards.
- Register 0: wa r0 = 0xFFFF and alloc r0 -> reads 0, rd_ready = 1, busy[0] = 0.
- Clear sweep:
  - Pulse clr_req -> clr_busy high for exactly 32 cycles, then a single clr_done pulse; all registers read 0; busy_vec = 0.
  - Write to r3 mid-sweep -> dropped; rd_ready = 0 throughout the sweep.
- Reset mid-sweep at cycle 10 -> clr_busy drops immediately, no clr_done, registers return to reset values.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, a per-register busy scoreboard
// and a sequenced bulk-clear engine. Register 0 is hardwired to zero.
//
// state | meaning
// IDLE  | normal operation: writes, allocates and bypass active
// SWEEP | zeroing one register per cycle; writes/allocs dropped, reads not ready
// DONE  | one-cycle completion pulse; writes/allocs accepted again
module reg_file_mp #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_RD     = 2,
  parameter int RESET_MODE = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("reg_file_mp: NUM_RD must be in 1..4");
  end

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic                sweep;
  logic                wa_ok, wb_ok, alloc_ok;

  // Address 0 never takes a write or an allocate.
  assign wa_ok    = wa_en    && !sweep && (wa_addr    != '0);
  assign wb_ok    = wb_en    && !sweep && (wb_addr    != '0);
  assign alloc_ok = alloc_en && !sweep && (alloc_addr != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sweep    = 1'b0;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      SWEEP: begin
        sweep    = 1'b1;
        clr_busy = 1'b1;
      end
      DONE:    clr_done = 1'b1;
      default: ;
    endcase
  end

  // Allocate is applied after the write clears so it wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (sweep) begin
      busy_d[cnt_q] = 1'b0;
    end else begin
      if (wa_ok)    busy_d[wa_addr]    = 1'b0;
      if (wb_ok)    busy_d[wb_addr]    = 1'b0;
      if (alloc_ok) busy_d[alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= (RESET_MODE == 1 && i != 0) ? DATA_W'(i) : '0;
    end else if (sweep) begin
      regs_q[cnt_q] <= '0;
    end else begin
      if (wa_ok) regs_q[wa_addr] <= wa_data;
      if (wb_ok) regs_q[wb_addr] <= wb_data;
    end
  end

  assign busy_vec = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ready;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data  = regs_q[addr];
      ready = ~busy_q[addr];
      if (addr == '0) begin
        data  = '0;
        ready = 1'b1;
      end else if (wb_ok && wb_addr == addr) begin
        data  = wb_data;
        ready = 1'b1;
      end else if (wa_ok && wa_addr == addr) begin
        data  = wa_data;
        ready = 1'b1;
      end
      if (sweep) ready = 1'b0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_ready[k]                 = ready;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp (DATA_W=32, ADDR_W=5, NUM_RD=2, RESET_MODE=1).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_reg_file_mp;

  logic        clk;
  logic        reset_n;
  logic [4:0]  a0, a1;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        wa_en, wb_en, alloc_en, clr_req;
  logic [4:0]  wa_addr, wb_addr, alloc_addr;
  logic [31:0] wa_data, wb_data;
  logic        clr_busy, clr_done;
  logic [31:0] busy_vec;
  logic [31:0] d0, d1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  assign rd_addr = {a1, a0};
  assign d0      = rd_data[31:0];
  assign d1      = rd_data[63:32];

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .RESET_MODE(1)) dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_ready(rd_ready), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .clr_req(clr_req), .clr_busy(clr_busy),
    .clr_done(clr_done), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i <= 10; i++) begin
      a0 = 5'(i);
      #1;
      total_cnt++;
      if (d0 !== 32'(i)) $display("FAIL reset_r%0d: got %h expected %h", i, d0, 32'(i));
      else pass_cnt++;
    end
    a1 = 5'd31;
    #1;
    total_cnt++;
    if (d1 !== 32'd31) $display("FAIL reset_r31: got %h expected %h", d1, 32'd31);
    else pass_cnt++;
    total_cnt++;
    if (busy_vec !== 32'h0) $display("FAIL reset_busy_vec: got %h expected 0", busy_vec);
    else pass_cnt++;
    total_cnt++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0)
      $display("FAIL reset_clr: got busy=%b done=%b expected 0/0", clr_busy, clr_done);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    a0 = 5'd10;
    #1;
    total_cnt++;
    if (d0 !== 32'd10) $display("FAIL post_reset_r10: got %h expected %h", d0, 32'd10);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h0000AAAA;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h00005555;
    a0 = 5'd5;
    #1;
    total_cnt++;
    if (d0 !== 32'h5555 || rd_ready[0] !== 1'b1)
      $display("FAIL same_cycle_bypass: got %h/%b expected 00005555/1", d0, rd_ready[0]);
    else pass_cnt++;
    @(negedge clk);
    wa_en = 1'b0; wb_en = 1'b0;
    #1;
    total_cnt++;
    if (d0 !== 32'h5555) $display("FAIL same_cycle_array: got %h expected 00005555", d0);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    alloc_en = 1'b1; alloc_addr = 5'd7; a0 = 5'd7;
    @(negedge clk);
    alloc_en = 1'b0;
    #1;
    total_cnt++;
    if (rd_ready[0] !== 1'b0 || busy_vec[7] !== 1'b1)
      $display("FAIL alloc_r7: got ready=%b busy=%b expected 0/1", rd_ready[0], busy_vec[7]);
    else pass_cnt++;
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1234;
    #1;
    total_cnt++;
    if (rd_ready[0] !== 1'b1 || d0 !== 32'h1234)
      $display("FAIL write_bypass_r7: got %h/%b expected 00001234/1", d0, rd_ready[0]);
    else pass_cnt++;
    @(negedge clk);
    wa_en = 1'b0;
    #1;
    total_cnt++;
    if (busy_vec[7] !== 1'b0 || rd_ready[0] !== 1'b1 || d0 !== 32'h1234)
      $display("FAIL writeback_r7: got %h/%b busy=%b expected 00001234/1 busy=0",
               d0, rd_ready[0], busy_vec[7]);
    else pass_cnt++;
    alloc_en = 1'b1; alloc_addr = 5'd7;
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'hBEEF;
    @(negedge clk);
    alloc_en = 1'b0; wa_en = 1'b0;
    #1;
    total_cnt++;
    if (busy_vec[7] !== 1'b1 || rd_ready[0] !== 1'b0 || d0 !== 32'hBEEF)
      $display("FAIL alloc_wins_r7: got %h/%b busy=%b expected 0000beef/0 busy=1",
               d0, rd_ready[0], busy_vec[7]);
    else pass_cnt++;
  endtask

  task automatic test_reg0();
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF;
    alloc_en = 1'b1; alloc_addr = 5'd0; a0 = 5'd0;
    #1;
    total_cnt++;
    if (d0 !== 32'h0 || rd_ready[0] !== 1'b1)
      $display("FAIL r0_same_cycle: got %h/%b expected 0/1", d0, rd_ready[0]);
    else pass_cnt++;
    @(negedge clk);
    wa_en = 1'b0; alloc_en = 1'b0;
    #1;
    total_cnt++;
    if (d0 !== 32'h0 || rd_ready[0] !== 1'b1 || busy_vec[0] !== 1'b0)
      $display("FAIL r0_after: got %h/%b busy=%b expected 0/1 busy=0",
               d0, rd_ready[0], busy_vec[0]);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    int busy_n = 0, done_n = 0, done_at = -1, ready_bad = 0, nz = 0;
    @(negedge clk);
    a0 = 5'd3; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if (it != 0) @(negedge clk);
      wa_en = (it == 10); wa_addr = 5'd3; wa_data = 32'hDEAD;
      alloc_en = (it == 10); alloc_addr = 5'd9;
      clr_req = (it == 15);
      #1;
      if (clr_busy === 1'b1) begin
        busy_n++;
        if (rd_ready[0] !== 1'b0) ready_bad++;
      end
      if (clr_done === 1'b1) begin
        done_n++;
        done_at = it;
      end
    end
    wa_en = 1'b0; alloc_en = 1'b0; clr_req = 1'b0;
    total_cnt++;
    if (busy_n !== 32) $display("FAIL sweep_busy_cycles: got %0d expected 32", busy_n);
    else pass_cnt++;
    total_cnt++;
    if (done_n !== 1 || done_at !== 32)
      $display("FAIL sweep_done_pulse: got count=%0d at=%0d expected 1 at 32", done_n, done_at);
    else pass_cnt++;
    total_cnt++;
    if (ready_bad !== 0) $display("FAIL sweep_ready_low: got %0d ready cycles expected 0", ready_bad);
    else pass_cnt++;
    for (int i = 0; i < 32; i++) begin
      a0 = 5'(i);
      #1;
      if (d0 !== 32'h0) nz++;
    end
    total_cnt++;
    if (nz !== 0) $display("FAIL sweep_all_zero: got %0d nonzero regs expected 0", nz);
    else pass_cnt++;
    total_cnt++;
    if (busy_vec !== 32'h0) $display("FAIL sweep_busy_vec: got %h expected 0", busy_vec);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_sweep();
    int done_seen = 0, busy_seen = 0;
    @(negedge clk);
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h77;
    @(negedge clk);
    wa_en = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0)
      $display("FAIL midsweep_reset_flags: got busy=%b done=%b expected 0/0", clr_busy, clr_done);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    a0 = 5'd1; a1 = 5'd3;
    #1;
    total_cnt++;
    if (d0 !== 32'd1 || d1 !== 32'd3)
      $display("FAIL midsweep_restore_r1_r3: got %h/%h expected 1/3", d0, d1);
    else pass_cnt++;
    a0 = 5'd20;
    #1;
    total_cnt++;
    if (d0 !== 32'd20 || busy_vec !== 32'h0)
      $display("FAIL midsweep_restore_r20: got %h busy=%h expected 20/0", d0, busy_vec);
    else pass_cnt++;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      #1;
      if (clr_done === 1'b1) done_seen++;
      if (clr_busy === 1'b1) busy_seen++;
    end
    total_cnt++;
    if (done_seen !== 0 || busy_seen !== 0)
      $display("FAIL midsweep_no_done: got done=%0d busy=%0d expected 0/0", done_seen, busy_seen);
    else pass_cnt++;
  endtask

  initial begin
    reset_n = 1'b0;
    a0 = '0; a1 = '0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; clr_req = 1'b0;
    test_reset();
    test_same_cycle();
    test_scoreboard();
    test_reg0();
    test_sweep();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
